// File: rtl/tlul_host_arb_pkg.sv
// Arbiter-specific shared types.
package tlul_host_arb_pkg;

  typedef enum logic {
    ArbIdle   = 1'b0,
    ArbLocked = 1'b1
  } arb_state_e;

endpackage

// File: rtl/tlul_pkg.sv
// TL-UL channel structs shared by every TL-UL block in the slice.
package tlul_pkg;

  localparam int TL_AIW = 8;
  localparam int TL_AW  = 32;
  localparam int TL_DW  = 32;
  localparam int TL_DBW = TL_DW / 8;
  localparam int TL_SZW = 2;
  localparam int TL_DIW = 1;

  typedef struct packed {
    logic              a_valid;
    logic [2:0]        a_opcode;
    logic [2:0]        a_param;
    logic [TL_SZW-1:0] a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    logic              d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic              d_valid;
    logic [2:0]        d_opcode;
    logic [2:0]        d_param;
    logic [TL_SZW-1:0] d_size;
    logic [TL_AIW-1:0] d_source;
    logic [TL_DIW-1:0] d_sink;
    logic [TL_DW-1:0]  d_data;
    logic              d_error;
    logic              a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/tlul_host_arb_if.sv
// Bundles the M host ports, the shared device port and the arbiter status outputs.
interface tlul_host_arb_if #(
  parameter int M = 2
);
  import tlul_pkg::*;

  tl_h2d_t        tl_h_i [M];
  tl_d2h_t        tl_h_o [M];
  tl_h2d_t        tl_d_o;
  tl_d2h_t        tl_d_i;
  logic [M-1:0]   grant_o;
  logic           route_err_o;

  modport slave (
    input  tl_h_i, tl_d_i,
    output tl_h_o, tl_d_o, grant_o, route_err_o
  );

  modport master (
    output tl_h_i, tl_d_i,
    input  tl_h_o, tl_d_o, grant_o, route_err_o
  );

endinterface

// File: rtl/tlul_host_arb_rr_pick.sv
// Combinational round-robin picker: first set bit of eligible_i at or after ptr_i, wrapping.
module tlul_rr_pick #(
  parameter  int N    = 2,
  localparam int IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    eligible_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic            valid_o,
  output logic [IdxW-1:0] idx_o
);

  logic [IdxW-1:0] cand;

  // Scanning from the farthest candidate back lets the closest one win last.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = IdxW'((int'(ptr_i) + k) % N);
      if (eligible_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/tlul_host_arb.sv
// Round-robin M:1 TL-UL host arbiter with grant locking, outstanding limits
// and source-ID tagging for routing D responses back to the issuing host.
module tlul_host_arb
  import tlul_pkg::*;
  import tlul_host_arb_pkg::*;
#(
  parameter int M              = 2,
  parameter int MaxOutstanding = 2
) (
  input  logic           clk_i,
  input  logic           rst_i,
  tlul_host_arb_if.slave bus
);

  localparam int IdW  = $clog2(M);
  localparam int OutW = $clog2(MaxOutstanding + 1);

  arb_state_e      state_q, state_d;
  logic [IdW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IdW-1:0]  lock_idx_q, lock_idx_d;
  logic [OutW-1:0] cnt_q [M];
  logic [OutW-1:0] cnt_d [M];

  logic [M-1:0]    eligible;
  logic            pick_valid;
  logic [IdW-1:0]  pick_idx;
  logic            sel_valid;
  logic [IdW-1:0]  sel_idx;
  logic            a_hs;
  logic [M-1:0]    a_inc;
  logic [M-1:0]    d_hs;
  logic [IdW-1:0]  d_idx;
  logic            d_idx_ok;

  function automatic logic [IdW-1:0] next_idx(input logic [IdW-1:0] i);
    return (int'(i) == M - 1) ? '0 : i + 1'b1;
  endfunction

  always_comb begin
    for (int i = 0; i < M; i++) begin
      eligible[i] = bus.tl_h_i[i].a_valid && (cnt_q[i] < OutW'(MaxOutstanding));
    end
  end

  tlul_rr_pick #(
    .N (M)
  ) u_pick (
    .eligible_i (eligible),
    .ptr_i      (rr_ptr_q),
    .valid_o    (pick_valid),
    .idx_o      (pick_idx)
  );

  // A locked grant ignores eligibility: the host must hold a_valid until accepted.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    if (!rst_i) begin
      if (state_q == ArbLocked) begin
        sel_valid = 1'b1;
        sel_idx   = lock_idx_q;
      end else begin
        sel_valid = pick_valid;
        sel_idx   = pick_idx;
      end
    end
  end

  always_comb begin
    bus.tl_d_o      = '0;
    bus.grant_o     = '0;
    bus.route_err_o = 1'b0;
    for (int i = 0; i < M; i++) begin
      bus.tl_h_o[i] = '0;
    end
    a_hs     = 1'b0;
    a_inc    = '0;
    d_hs     = '0;
    d_idx    = bus.tl_d_i.d_source[IdW-1:0];
    d_idx_ok = (int'(d_idx) < M);

    if (sel_valid) begin
      bus.grant_o[sel_idx]  = 1'b1;
      bus.tl_d_o            = bus.tl_h_i[sel_idx];
      bus.tl_d_o.a_source   = (bus.tl_h_i[sel_idx].a_source << IdW) | TL_AIW'(sel_idx);
      bus.tl_d_o.d_ready    = 1'b0;
      a_hs                  = bus.tl_h_i[sel_idx].a_valid && bus.tl_d_i.a_ready;
      a_inc[sel_idx]        = a_hs;
    end

    // Responses carrying an index with no host behind it are drained and flagged.
    if (!rst_i) begin
      if (d_idx_ok) begin
        bus.tl_d_o.d_ready         = bus.tl_h_i[d_idx].d_ready;
        bus.tl_h_o[d_idx]          = bus.tl_d_i;
        bus.tl_h_o[d_idx].d_source = bus.tl_d_i.d_source >> IdW;
        bus.tl_h_o[d_idx].a_ready  = 1'b0;
        d_hs[d_idx]                = bus.tl_d_i.d_valid && bus.tl_h_i[d_idx].d_ready;
      end else begin
        bus.tl_d_o.d_ready = 1'b1;
        bus.route_err_o    = bus.tl_d_i.d_valid;
      end
    end

    if (sel_valid) begin
      bus.tl_h_o[sel_idx].a_ready = bus.tl_d_i.a_ready;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lock_idx_d = lock_idx_q;
    case (state_q)
      ArbIdle: begin
        if (pick_valid) begin
          if (a_hs) begin
            rr_ptr_d = next_idx(pick_idx);
          end else begin
            state_d    = ArbLocked;
            lock_idx_d = pick_idx;
          end
        end
      end
      ArbLocked: begin
        if (a_hs) begin
          state_d  = ArbIdle;
          rr_ptr_d = next_idx(lock_idx_q);
        end
      end
      default: state_d = ArbIdle;
    endcase
  end

  always_comb begin
    for (int i = 0; i < M; i++) begin
      cnt_d[i] = cnt_q[i];
      if (a_inc[i] && !d_hs[i]) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (!a_inc[i] && d_hs[i]) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ArbIdle;
      rr_ptr_q   <= '0;
      lock_idx_q <= '0;
      for (int i = 0; i < M; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_idx_q <= lock_idx_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule
